// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM bus controller: FSM state encoding,
// default access length and wait-counter width.
package sram_bus_pkg;

  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

endpackage

// File: rtl/sram_bus_ctrl.sv
// Single-word asynchronous SRAM controller behind an L2 request/acknowledge bus.
// Define SRAM_BUS_CTRL_ADDR_CHECK_EN to reject out-of-range addresses and add err_count.
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bus_rreq,
  input  logic               bus_wreq,
  input  logic [31:0]        bus_addr,
  input  logic [31:0]        bus_wdata,
  output logic [31:0]        bus_rdata,
  output logic               bus_acc,
  output logic               bus_busy,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
`ifdef SRAM_BUS_CTRL_ADDR_CHECK_EN
  ,
  output logic [15:0]        err_count
`endif
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               wr_q, wr_d;
  logic               busy_q, busy_d;

  logic req;
  logic addr_bad;
  logic unused_addr;

  assign req = bus_rreq | bus_wreq;

`ifdef SRAM_BUS_CTRL_ADDR_CHECK_EN
  assign addr_bad    = |bus_addr[31:SRAM_AW+2];
  assign unused_addr = ^bus_addr[1:0];
`else
  assign addr_bad    = 1'b0;
  assign unused_addr = ^{bus_addr[31:SRAM_AW+2], bus_addr[1:0]};
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = bus_addr[SRAM_AW+1:2];
          wdata_d = bus_wdata;
          wr_d    = bus_wreq;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = addr_bad ? ACK : ACCESS;
          if (addr_bad && !bus_wreq) rdata_d = '0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ACK;
          if (!wr_q) rdata_d = sram_dq_i;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  logic in_access;
  logic last_cycle;

  assign in_access  = (state_q == ACCESS);
  assign last_cycle = (cnt_q == CNT_W'(1));

  // we_n rises one cycle early so write data is still driven for hold time.
  assign sram_ce_n  = ~in_access;
  assign sram_be_n  = in_access ? 4'h0 : 4'hF;
  assign sram_oe_n  = ~(in_access & ~wr_q);
  assign sram_we_n  = ~(in_access & wr_q & ~last_cycle);
  assign sram_dq_oe = in_access & wr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_addr  = addr_q;

  assign bus_acc   = (state_q == ACK);
  assign bus_busy  = busy_q;
  assign bus_rdata = rdata_q;

`ifdef SRAM_BUS_CTRL_ADDR_CHECK_EN
  logic [15:0] err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else if (state_q == IDLE && req && addr_bad && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end

  assign err_count = err_q;
`endif

endmodule
